// File: rtl/mult_host_pkg.sv
// Shared types and constants for the multiplier host controller.
package mult_host_pkg;

  localparam int unsigned LOGDEPTH_DEFAULT = 6;
  localparam int unsigned DEPTH            = 1 << LOGDEPTH_DEFAULT;

  typedef enum logic [2:0] {
    FILL      = 3'd0,
    STREAM    = 3'd1,
    WAIT_FULL = 3'd2,
    REQ       = 3'd3,
    COLLECT   = 3'd4
  } host_state_t;

  function automatic int unsigned depth_of(input int unsigned logdepth);
    return 1 << logdepth;
  endfunction

endpackage

// File: rtl/mult_host_op_buffer.sv
// Operand-pair register file: one write port, one registered read port.
module op_buffer
  import mult_host_pkg::*;
#(
  parameter int unsigned ADDRW = 6,
  parameter int unsigned DATAW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ADDRW-1:0] waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic             rd_en,
  input  logic [ADDRW-1:0] raddr,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem [depth_of(ADDRW)];

  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= wdata;
  end

  // Read data returns to zero when idle so it can drive the multiplier operands directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= mem[raddr];
    else            rdata <= '0;
  end

endmodule

// File: rtl/mult_host.sv
// Host controller: buffers operand pairs, streams them to the multiplier,
// then collects the read-back products and their block sum.
module mult_host
  import mult_host_pkg::*;
#(
  parameter int unsigned LOGDEPTH = LOGDEPTH_DEFAULT,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned OPW      = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [OPW-1:0]            op_a,
  input  logic [OPW-1:0]            op_b,
  output logic                      EN_mult,
  output logic [OPW-1:0]            mult_input0,
  output logic [OPW-1:0]            mult_input1,
  input  logic                      RDY_mult,
  output logic                      EN_blockRead,
  input  logic                      VALID_memVal,
  input  logic [WIDTH-1:0]          memVal_data,
  output logic                      res_valid,
  output logic [WIDTH-1:0]          res_data,
  output logic [LOGDEPTH-1:0]       res_index,
  output logic                      res_last,
  output logic                      sum_valid,
  output logic [WIDTH+LOGDEPTH-1:0] block_sum,
  output logic                      err_timeout
);

  localparam int unsigned     TW       = $clog2(TIMEOUT + 1);
  localparam logic [LOGDEPTH:0] FULL   = {1'b1, {LOGDEPTH{1'b0}}};
  localparam logic [TW-1:0]   IDLE_MAX = TW'(TIMEOUT - 1);

  host_state_t         state, state_d;
  logic [LOGDEPTH:0]   cnt, cnt_d;
  logic [TW-1:0]       idle, idle_d;
  logic                wr_en, rd_en, start_d, req_d, beat, finish_d, tmo_d;
  logic [LOGDEPTH-1:0] raddr;
  logic [2*OPW-1:0]    rdata;

  assign op_ready    = !rst && (state == FILL) && (cnt < FULL);
  assign mult_input0 = rdata[OPW-1:0];
  assign mult_input1 = rdata[2*OPW-1:OPW];

  op_buffer #(.ADDRW(LOGDEPTH), .DATAW(2*OPW)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .waddr (cnt[LOGDEPTH-1:0]),
    .wdata ({op_b, op_a}),
    .rd_en (rd_en),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
      idle  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idle  <= idle_d;
    end
  end

  // Reads are issued one cycle ahead so pair k appears in STREAM cycle k.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idle_d   = idle;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    raddr    = '0;
    start_d  = 1'b0;
    req_d    = 1'b0;
    beat     = 1'b0;
    finish_d = 1'b0;
    tmo_d    = 1'b0;
    case (state)
      FILL: begin
        if (cnt == FULL) begin
          if (RDY_mult) begin
            state_d = STREAM;
            cnt_d   = '0;
            rd_en   = 1'b1;
            start_d = 1'b1;
          end
        end else if (op_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt + 1'b1;
        end
      end
      STREAM: begin
        if (&cnt[LOGDEPTH-1:0]) begin
          state_d = WAIT_FULL;
          cnt_d   = '0;
        end else begin
          rd_en = 1'b1;
          raddr = cnt[LOGDEPTH-1:0] + LOGDEPTH'(1);
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_FULL: begin
        if (!RDY_mult) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        state_d = COLLECT;
        cnt_d   = '0;
        idle_d  = '0;
      end
      COLLECT: begin
        if (cnt == FULL) begin
          finish_d = 1'b1;
          state_d  = FILL;
          cnt_d    = '0;
        end else if (VALID_memVal) begin
          beat   = 1'b1;
          cnt_d  = cnt + 1'b1;
          idle_d = '0;
        end else if (idle == IDLE_MAX) begin
          tmo_d    = 1'b1;
          finish_d = 1'b1;
          state_d  = FILL;
          cnt_d    = '0;
        end else begin
          idle_d = idle + 1'b1;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EN_mult      <= 1'b0;
      EN_blockRead <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_index    <= '0;
      res_last     <= 1'b0;
      sum_valid    <= 1'b0;
      block_sum    <= '0;
      err_timeout  <= 1'b0;
    end else begin
      EN_mult      <= start_d;
      EN_blockRead <= req_d;
      res_valid    <= beat;
      res_last     <= beat && (&cnt[LOGDEPTH-1:0]);
      sum_valid    <= finish_d;
      if (beat) begin
        res_data  <= memVal_data;
        res_index <= cnt[LOGDEPTH-1:0];
      end
      if (state == REQ)
        block_sum <= '0;
      else if (beat)
        block_sum <= block_sum + {{LOGDEPTH{1'b0}}, memVal_data};
      if (tmo_d) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_host.sv
// Scoreboard bench for mult_host: stimulus pushes expectations, monitors pop and compare.
module tb_mult_host;
  import mult_host_pkg::*;

  logic        clk, rst, op_valid, op_ready;
  logic [15:0] op_a, op_b, mult_input0, mult_input1;
  logic        EN_mult, RDY_mult, EN_blockRead, VALID_memVal;
  logic [31:0] memVal_data, res_data;
  logic        res_valid, res_last, sum_valid, err_timeout;
  logic [5:0]  res_index;
  logic [37:0] block_sum;

  mult_host #(.LOGDEPTH(6), .WIDTH(32), .OPW(16), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .EN_mult(EN_mult),
    .mult_input0(mult_input0), .mult_input1(mult_input1),
    .RDY_mult(RDY_mult), .EN_blockRead(EN_blockRead),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
    .res_last(res_last), .sum_valid(sum_valid), .block_sum(block_sum),
    .err_timeout(err_timeout)
  );

  typedef struct { logic [31:0] d; logic [5:0] idx; logic last; } res_t;
  typedef struct { logic [37:0] s; logic err; } sum_t;

  logic [31:0] q_mult [$];
  res_t        q_res  [$];
  sum_t        q_sum  [$];

  int vectors = 0, miscompares = 0;
  int en_mult_cnt = 0, en_br_cnt = 0, sum_cnt = 0, stream_done = 0;
  int stream_left = 0, cyc = 0, last_res_cyc = 0, sum_gap = 0;
  bit zero_chk = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pair(input int mode, input int k);
    logic [15:0] a, b;
    case (mode)
      0:       begin a = 16'(k);           b = 16'(k + 1); end
      1:       begin a = 16'hFFFF - 16'(k); b = 16'(k * 3); end
      default: begin a = 16'(k << 8);      b = ~16'(k);    end
    endcase
    return {b, a};
  endfunction

  function automatic int evt(input int sel);
    case (sel)
      0:       return en_mult_cnt;
      1:       return en_br_cnt;
      2:       return sum_cnt;
      default: return stream_done;
    endcase
  endfunction

  task automatic wait_evt(input int sel, input int budget, input string nm);
    int t0, i;
    t0 = evt(sel);
    i  = 0;
    while (evt(sel) == t0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(nm, 64'(evt(sel) != t0), 64'd1);
  endtask

  // Multiplier-side monitor: a 64-cycle window opens on EN_mult.
  always @(negedge clk) begin
    if (rst) begin
      stream_left = 0;
      zero_chk    = 0;
    end else begin
      if (zero_chk) begin
        chk("mult_idle_in0", 64'(mult_input0), 64'd0);
        chk("mult_idle_in1", 64'(mult_input1), 64'd0);
        zero_chk = 0;
      end
      if (EN_mult) begin
        en_mult_cnt++;
        chk("en_mult_outside_window", 64'(stream_left), 64'd0);
        if (stream_left == 0) stream_left = 64;
      end
      if (stream_left > 0) begin
        if (q_mult.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL mult_unexpected: actual=%0h expected=none", {mult_input1, mult_input0});
        end else begin
          chk("mult_pair", 64'({mult_input1, mult_input0}), 64'(q_mult.pop_front()));
        end
        stream_left--;
        if (stream_left == 0) begin
          stream_done++;
          zero_chk = 1;
        end
      end
    end
  end

  // Read-back monitor: results, block sum and request pulses.
  always @(negedge clk) begin
    res_t r;
    sum_t s;
    cyc++;
    if (!rst) begin
      if (EN_blockRead) en_br_cnt++;
      if (res_valid) begin
        if (q_res.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL res_unexpected: actual=%0h expected=none", res_data);
        end else begin
          r = q_res.pop_front();
          chk("res_data",  64'(res_data),  64'(r.d));
          chk("res_index", 64'(res_index), 64'(r.idx));
          chk("res_last",  64'(res_last),  64'(r.last));
        end
        last_res_cyc = cyc;
      end
      if (sum_valid) begin
        if (q_sum.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL sum_unexpected: actual=%0h expected=none", block_sum);
        end else begin
          s = q_sum.pop_front();
          chk("block_sum",   64'(block_sum),   64'(s.s));
          chk("err_at_sum",  64'(err_timeout), 64'(s.err));
        end
        sum_gap = cyc - last_res_cyc;
        sum_cnt++;
      end
    end
  end

  task automatic fill(input int mode, input int start, input int n);
    for (int k = start; k < start + n; k++) begin
      logic [31:0] p;
      int w;
      p = pair(mode, k);
      op_valid = 1'b1;
      op_a = p[15:0];
      op_b = p[31:16];
      w = 0;
      while (!op_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!op_ready) chk("fill_ready", 64'(op_ready), 64'd1);
      q_mult.push_back(p);
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
  endtask

  task automatic beats(input int n, input int mode, input int maxgap);
    for (int k = 0; k < n; k++) begin
      int g;
      logic [31:0] d;
      res_t r;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      case (mode)
        0:       d = 32'hFFFF_FFFF;
        1:       d = 32'(2 * k);
        default: d = 32'd5;
      endcase
      repeat (g) begin @(posedge clk); #1; VALID_memVal = 1'b0; end
      @(posedge clk); #1;
      VALID_memVal = 1'b1;
      memVal_data  = d;
      r.d = d; r.idx = 6'(k); r.last = (k == 63);
      q_res.push_back(r);
    end
    @(posedge clk); #1;
    VALID_memVal = 1'b0;
  endtask

  task automatic prep_block(input int mode, input string nm);
    fill(mode, 0, DEPTH);
    RDY_mult = 1'b1;
    wait_evt(3, 200, {nm, "_stream"});
    @(posedge clk); #1;
    RDY_mult = 1'b0;
    wait_evt(1, 20, {nm, "_blockread"});
  endtask

  initial begin
    sum_t s;
    int n0;
    rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0;
    RDY_mult = 1'b0; VALID_memVal = 1'b0; memVal_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_op_ready",  64'(op_ready),     64'd0);
    chk("rst_en_mult",   64'(EN_mult),      64'd0);
    chk("rst_en_br",     64'(EN_blockRead), 64'd0);
    chk("rst_res_valid", 64'(res_valid),    64'd0);
    chk("rst_sum_valid", 64'(sum_valid),    64'd0);
    chk("rst_block_sum", 64'(block_sum),    64'd0);
    chk("rst_err",       64'(err_timeout),  64'd0);
    chk("rst_mult_in",   64'({mult_input1, mult_input0}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("op_ready_after_rst", 64'(op_ready), 64'd1);

    // Fill with RDY_mult low: host must hold after 64 pairs.
    @(posedge clk); #1;
    fill(0, 0, DEPTH);
    op_valid = 1'b1; op_a = 16'd99; op_b = 16'd99;
    @(negedge clk);
    chk("op_ready_full", 64'(op_ready), 64'd0);
    repeat (3) @(negedge clk);
    chk("hold_fill_no_start", 64'(en_mult_cnt), 64'd0);
    chk("hold_fill_ready",    64'(op_ready),    64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;

    // Stream.
    RDY_mult = 1'b1;
    wait_evt(3, 200, "stream1");
    chk("en_mult_pulses", 64'(en_mult_cnt), 64'd1);

    // Back-to-back read-back of all-ones.
    @(posedge clk); #1;
    RDY_mult = 1'b0;
    wait_evt(1, 20, "blockread1");
    s.s = 38'h3F_FFFF_FFC0; s.err = 1'b0; q_sum.push_back(s);
    beats(64, 0, 0);
    wait_evt(2, 50, "sum1");
    chk("sum_latency",      64'(sum_gap),   64'd1);
    chk("blockread_pulses", 64'(en_br_cnt), 64'd1);
    chk("sum_pulses",       64'(sum_cnt),   64'd1);
    chk("back_to_fill",     64'(op_ready),  64'd1);

    // Gapped beats: sum of 2k over 0..63.
    @(posedge clk); #1;
    prep_block(1, "blk2");
    s.s = 38'd4032; s.err = 1'b0; q_sum.push_back(s);
    beats(64, 1, 20);
    wait_evt(2, 50, "sum2");
    chk("gapped_no_timeout", 64'(err_timeout), 64'd0);

    // Timeout after 10 beats of 5.
    @(posedge clk); #1;
    prep_block(2, "blk3");
    s.s = 38'd50; s.err = 1'b1; q_sum.push_back(s);
    beats(10, 2, 0);
    wait_evt(2, 400, "sum_timeout");
    chk("timeout_idle_cycles", 64'(sum_gap),     64'd255);
    chk("timeout_err",         64'(err_timeout), 64'd1);
    chk("timeout_to_fill",     64'(op_ready),    64'd1);

    // Reset in the middle of streaming.
    @(posedge clk); #1;
    fill(0, 0, DEPTH);
    RDY_mult = 1'b1;
    wait_evt(0, 20, "start4");
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    q_mult.delete();
    @(negedge clk);
    chk("mid_rst_en_mult",   64'(EN_mult),     64'd0);
    chk("mid_rst_mult_in",   64'({mult_input1, mult_input0}), 64'd0);
    chk("mid_rst_err",       64'(err_timeout), 64'd0);
    chk("mid_rst_block_sum", 64'(block_sum),   64'd0);
    chk("mid_rst_res",       64'({res_valid, res_last, res_index, res_data}), 64'd0);
    chk("mid_rst_op_ready",  64'(op_ready),    64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(op_ready), 64'd1);
    n0 = en_mult_cnt;
    @(posedge clk); #1;
    fill(0, 100, 63);
    repeat (10) @(negedge clk);
    chk("no_start_at_63", 64'(en_mult_cnt), 64'(n0));
    @(posedge clk); #1;
    fill(0, 163, 1);
    wait_evt(3, 200, "stream_after_rst");
    chk("restart_pulse", 64'(en_mult_cnt), 64'(n0 + 1));

    repeat (3) @(negedge clk);
    chk("q_mult_drained", 64'(q_mult.size()), 64'd0);
    chk("q_res_drained",  64'(q_res.size()),  64'd0);
    chk("q_sum_drained",  64'(q_sum.size()),  64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
